// File: rtl/bcd_counter_pkg.sv
// Shared types and helpers for the BCD counter sequencer and its datapath.
package bcd_counter_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      STOPPED   = 2'd0,
      RUNNING   = 2'd1,
      SATURATED = 2'd2
   } ctrl_state_t;

   localparam bcd_digit_t BCD_MAX = 4'h9;

   // Sanitise a loaded digit: anything above 9 is pinned to 9.
   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_incrementer.sv
// Combinational BCD incrementer: adds one to a DIGITS-wide BCD value.
// carry_out is high when every digit was >= 9 (the all-9s case).
module bcd_incrementer
   import bcd_counter_pkg::*;
#(
   parameter int unsigned DIGITS = 6
) (
   input  logic [DIGITS-1:0][3:0] bcd_in,
   output logic [DIGITS-1:0][3:0] bcd_out,
   output logic                   carry_out
);

   logic carry_c;

   // Ripple from digit 0: digits >= 9 wrap to 0 and carry, first digit < 9 absorbs the carry.
   always_comb begin
      carry_c = 1'b1;
      bcd_out = bcd_in;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (carry_c) begin
            if (bcd_in[i] >= BCD_MAX) begin
               bcd_out[i] = '0;
            end else begin
               bcd_out[i] = bcd_in[i] + 4'd1;
               carry_c    = 1'b0;
            end
         end
      end
      carry_out = carry_c;
   end

endmodule

// File: rtl/tick_prescaler.sv
// Divides clk into a one-cycle tick every TICK_DIV enabled cycles.
// enable must come from registered state so tick has no input-to-output path.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 5_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   input  logic hold,
   output logic tick
);

   localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: restart wins, otherwise advance and wrap while enabled and not held.
   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (enable && !hold) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Prescaler register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = enable && (cnt_q == CNT_MAX);

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Sequencer for the seven-segment BCD counter: owns the count register,
// the run/stop/saturate state and the count-tick prescaler.
module bcd_counter_ctrl
   import bcd_counter_pkg::*;
#(
   parameter int unsigned DIGITS   = 6,
   parameter int unsigned TICK_DIV = 5_000_000,
   parameter bit          WRAP     = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   clear,
   input  logic                   load,
   input  logic [DIGITS-1:0][3:0] load_value,
   output logic [DIGITS-1:0][3:0] count_out,
   output logic                   running,
   output logic                   done,
   output logic                   rollover,
   output logic                   tick
);

   ctrl_state_t            state_q;
   ctrl_state_t            state_d;
   logic [DIGITS-1:0][3:0] count_q;
   logic [DIGITS-1:0][3:0] count_d;
   logic                   running_q;
   logic                   running_d;
   logic                   done_q;
   logic                   done_d;
   logic                   rollover_q;
   logic                   rollover_d;

   logic                   presc_restart;
   logic                   presc_hold;
   logic                   tick_w;
   logic [DIGITS-1:0][3:0] inc_count;
   logic                   inc_all9;

   bcd_incrementer #(
      .DIGITS (DIGITS)
   ) u_incr (
      .bcd_in    (count_q),
      .bcd_out   (inc_count),
      .carry_out (inc_all9)
   );

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_presc (
      .clk     (clk),
      .reset   (reset),
      .enable  (running_q),
      .restart (presc_restart),
      .hold    (presc_hold),
      .tick    (tick_w)
   );

   // Command decode, priority clear > load > stop > start > tick; start only counts as a command from STOPPED.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      rollover_d    = 1'b0;
      presc_restart = 1'b0;
      presc_hold    = 1'b0;
      if (clear) begin
         count_d       = '0;
         state_d       = STOPPED;
         presc_restart = 1'b1;
      end else if (load) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            count_d[i] = bcd_clamp(load_value[i]);
         end
         state_d       = STOPPED;
         presc_restart = 1'b1;
      end else if (stop) begin
         presc_hold = 1'b1;
         if (state_q == RUNNING) begin
            state_d = STOPPED;
         end
      end else if (start && (state_q == STOPPED)) begin
         state_d       = RUNNING;
         presc_restart = 1'b1;
      end else if (tick_w) begin
         if (inc_all9 && !WRAP) begin
            state_d = SATURATED;
         end else begin
            count_d    = inc_count;
            rollover_d = inc_all9;
         end
      end
      running_d = (state_d == RUNNING);
      done_d    = (state_d == SATURATED);
   end

   // State, count and status flags, all registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= STOPPED;
         count_q    <= '0;
         running_q  <= 1'b0;
         done_q     <= 1'b0;
         rollover_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         running_q  <= running_d;
         done_q     <= done_d;
         rollover_q <= rollover_d;
      end
   end

   assign count_out = count_q;
   assign running   = running_q;
   assign done      = done_q;
   assign rollover  = rollover_q;
   assign tick      = tick_w;

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Scoreboard bench for bcd_counter_ctrl: three instances (wrap, saturate, divide-by-1).
module tb_bcd_counter_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // DUT A: DIGITS=3, TICK_DIV=4, WRAP=1
   logic start_a = 0, stop_a = 0, clear_a = 0, load_a = 0;
   logic [2:0][3:0] lv_a = '0;
   logic [2:0][3:0] cnt_a;
   logic run_a, done_a, roll_a, tick_a;

   // DUT B: DIGITS=3, TICK_DIV=4, WRAP=0
   logic start_b = 0, stop_b = 0, clear_b = 0, load_b = 0;
   logic [2:0][3:0] lv_b = '0;
   logic [2:0][3:0] cnt_b;
   logic run_b, done_b, roll_b, tick_b;

   // DUT C: DIGITS=2, TICK_DIV=1, WRAP=1
   logic start_c = 0, stop_c = 0, clear_c = 0, load_c = 0;
   logic [1:0][3:0] lv_c = '0;
   logic [1:0][3:0] cnt_c;
   logic run_c, done_c, roll_c, tick_c;

   bcd_counter_ctrl #(.DIGITS(3), .TICK_DIV(4), .WRAP(1'b1)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .clear(clear_a),
      .load(load_a), .load_value(lv_a), .count_out(cnt_a), .running(run_a),
      .done(done_a), .rollover(roll_a), .tick(tick_a));

   bcd_counter_ctrl #(.DIGITS(3), .TICK_DIV(4), .WRAP(1'b0)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .clear(clear_b),
      .load(load_b), .load_value(lv_b), .count_out(cnt_b), .running(run_b),
      .done(done_b), .rollover(roll_b), .tick(tick_b));

   bcd_counter_ctrl #(.DIGITS(2), .TICK_DIV(1), .WRAP(1'b1)) dut_c (
      .clk(clk), .reset(reset), .start(start_c), .stop(stop_c), .clear(clear_c),
      .load(load_c), .load_value(lv_c), .count_out(cnt_c), .running(run_c),
      .done(done_c), .rollover(roll_c), .tick(tick_c));

   typedef struct {
      int          cyc;
      int          dut;
      logic [11:0] count;
      logic        run;
      logic        done;
      logic        roll;
      logic        tick;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   errors  = 0;

   // Queue an expectation for the negedge 'off' cycles from now.
   task automatic ex(input int d, input int off, input logic [11:0] c,
                     input logic r, input logic dn, input logic ro, input logic tk,
                     input string nm);
      exp_t e;
      e.cyc = cyc + off; e.dut = d; e.count = c;
      e.run = r; e.done = dn; e.roll = ro; e.tick = tk; e.name = nm;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: on each negedge compare every expectation due this cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            logic [11:0] ac;
            logic ar, ad, aro, at;
            case (sb[i].dut)
               0:       begin ac = cnt_a;         ar = run_a; ad = done_a; aro = roll_a; at = tick_a; end
               1:       begin ac = cnt_b;         ar = run_b; ad = done_b; aro = roll_b; at = tick_b; end
               default: begin ac = {4'h0, cnt_c}; ar = run_c; ad = done_c; aro = roll_c; at = tick_c; end
            endcase
            vectors++;
            if (ac !== sb[i].count || ar !== sb[i].run || ad !== sb[i].done ||
                aro !== sb[i].roll || at !== sb[i].tick) begin
               errors++;
               $display("FAIL %s @cyc %0d: got count=%h run=%b done=%b roll=%b tick=%b, want count=%h run=%b done=%b roll=%b tick=%b",
                        sb[i].name, cyc, ac, ar, ad, aro, at,
                        sb[i].count, sb[i].run, sb[i].done, sb[i].roll, sb[i].tick);
            end
            sb.delete(i);
         end else if (sb[i].cyc < cyc) begin
            errors++;
            $display("FAIL %s: expectation for cyc %0d never checked (now %0d)", sb[i].name, sb[i].cyc, cyc);
            sb.delete(i);
         end
      end
   end

   initial begin
      step(2);
      reset = 1'b0;
      ex(0, 0, 12'h000, 0, 0, 0, 0, "a_reset");
      ex(1, 0, 12'h000, 0, 0, 0, 0, "b_reset");
      ex(2, 0, 12'h000, 0, 0, 0, 0, "c_reset");

      // A: basic counting, ticks 4/8/12 cycles after start
      start_a = 1; step(1); start_a = 0;
      ex(0, 0,  12'h000, 1, 0, 0, 0, "a_run");
      ex(0, 2,  12'h000, 1, 0, 0, 0, "a_pre_tick");
      ex(0, 3,  12'h000, 1, 0, 0, 1, "a_tick1");
      ex(0, 4,  12'h001, 1, 0, 0, 0, "a_cnt1");
      ex(0, 7,  12'h001, 1, 0, 0, 1, "a_tick2");
      ex(0, 8,  12'h002, 1, 0, 0, 0, "a_cnt2");
      ex(0, 11, 12'h002, 1, 0, 0, 1, "a_tick3");
      ex(0, 12, 12'h003, 1, 0, 0, 0, "a_cnt3");
      step(12);

      // A: stop on a tick cycle at 041, restart counts from 0
      load_a = 1; lv_a = 12'h040; step(1); load_a = 0;
      ex(0, 0, 12'h040, 0, 0, 0, 0, "a_load040");
      start_a = 1; step(1); start_a = 0;
      ex(0, 0, 12'h040, 1, 0, 0, 0, "a_run040");
      ex(0, 4, 12'h041, 1, 0, 0, 0, "a_cnt041");
      ex(0, 7, 12'h041, 1, 0, 0, 1, "a_stop_tick");
      step(7);
      stop_a = 1; step(1); stop_a = 0;
      ex(0, 0, 12'h041, 0, 0, 0, 0, "a_stopped");
      ex(0, 3, 12'h041, 0, 0, 0, 0, "a_hold");
      step(3);
      start_a = 1; step(1); start_a = 0;
      ex(0, 0, 12'h041, 1, 0, 0, 0, "a_restart_no_tick");
      ex(0, 2, 12'h041, 1, 0, 0, 0, "a_restart_pre");
      ex(0, 3, 12'h041, 1, 0, 0, 1, "a_tick_after_restart");
      ex(0, 4, 12'h042, 1, 0, 0, 0, "a_cnt042");
      step(4);

      // A: 998 -> 999 -> 000 with a single rollover pulse
      load_a = 1; lv_a = 12'h998; step(1); load_a = 0;
      ex(0, 0, 12'h998, 0, 0, 0, 0, "a_load998");
      start_a = 1; step(1); start_a = 0;
      ex(0, 4, 12'h999, 1, 0, 0, 0, "a_999");
      ex(0, 7, 12'h999, 1, 0, 0, 1, "a_tick_at_999");
      ex(0, 8, 12'h000, 1, 0, 1, 0, "a_rollover");
      ex(0, 9, 12'h000, 1, 0, 0, 0, "a_roll_pulse_end");
      step(9);

      // A: load beats start, digits clamped
      load_a = 1; start_a = 1; lv_a = 12'hA3F; step(1); load_a = 0; start_a = 0;
      ex(0, 0, 12'h939, 0, 0, 0, 0, "a_load_clamp");
      ex(0, 5, 12'h939, 0, 0, 0, 0, "a_start_lost");
      step(5);

      // A: clear beats load while running at 517
      load_a = 1; lv_a = 12'h516; step(1); load_a = 0;
      start_a = 1; step(1); start_a = 0;
      ex(0, 4, 12'h517, 1, 0, 0, 0, "a_517");
      step(4);
      clear_a = 1; load_a = 1; lv_a = 12'h123; step(1); clear_a = 0; load_a = 0;
      ex(0, 0, 12'h000, 0, 0, 0, 0, "a_clear_over_load");

      // A: reset mid-run at 517
      load_a = 1; lv_a = 12'h516; step(1); load_a = 0;
      start_a = 1; step(1); start_a = 0;
      ex(0, 5, 12'h517, 1, 0, 0, 0, "a_517_again");
      step(5);
      reset = 1; step(1); reset = 0;
      ex(0, 0, 12'h000, 0, 0, 0, 0, "a_reset_mid_run");
      ex(0, 4, 12'h000, 0, 0, 0, 0, "a_idle_after_reset");
      step(4);

      // B: saturate at 999
      load_b = 1; lv_b = 12'h999; step(1); load_b = 0;
      ex(1, 0, 12'h999, 0, 0, 0, 0, "b_load999");
      start_b = 1; step(1); start_b = 0;
      ex(1, 0, 12'h999, 1, 0, 0, 0, "b_run");
      ex(1, 3, 12'h999, 1, 0, 0, 1, "b_tick_at_999");
      ex(1, 4, 12'h999, 0, 1, 0, 0, "b_saturated");
      step(4);
      start_b = 1; step(2); start_b = 0;
      ex(1, 0, 12'h999, 0, 1, 0, 0, "b_start_ignored");
      ex(1, 2, 12'h999, 0, 1, 0, 0, "b_still_saturated");
      step(2);
      clear_b = 1; step(1); clear_b = 0;
      ex(1, 0, 12'h000, 0, 0, 0, 0, "b_clear");
      step(1);

      // C: TICK_DIV=1 ticks every running cycle
      start_c = 1; step(1); start_c = 0;
      ex(2, 0, 12'h000, 1, 0, 0, 1, "c_tick0");
      ex(2, 1, 12'h001, 1, 0, 0, 1, "c_cnt01");
      ex(2, 2, 12'h002, 1, 0, 0, 1, "c_cnt02");
      step(2);
      load_c = 1; lv_c = 8'h98; step(1); load_c = 0;
      ex(2, 0, 12'h098, 0, 0, 0, 0, "c_load98");
      start_c = 1; step(1); start_c = 0;
      ex(2, 0, 12'h098, 1, 0, 0, 1, "c_run98");
      ex(2, 1, 12'h099, 1, 0, 0, 1, "c_99");
      ex(2, 2, 12'h000, 1, 0, 1, 1, "c_rollover");
      ex(2, 3, 12'h001, 1, 0, 0, 1, "c_after_roll");
      step(3);
      stop_c = 1; step(1); stop_c = 0;
      ex(2, 0, 12'h001, 0, 0, 0, 0, "c_stop");

      // Drain the scoreboard with a bounded wait.
      for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
      while (sb.size() > 0) begin
         errors++;
         $display("FAIL %s: expectation for cyc %0d left unchecked", sb[0].name, sb[0].cyc);
         void'(sb.pop_front());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
